// File: rtl/aes_dec_pkg.sv
// Shared constants, S-box tables, GF(2^8) helpers and key-schedule steps for
// the iterative AES-128 inverse cipher.
// Optional build macro: AES_DEC_FWD_KEY_EN (key port takes the cipher key k0
// and a forward-expansion PREP phase derives k10 before decryption).
package aes_dec_pkg;

    localparam int NR     = 10;
    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;
    localparam int RND_W  = 4;

    localparam logic [RND_W-1:0] RND_MAX = RND_W'(NR);

`ifdef AES_DEC_FWD_KEY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PREP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    // Forward S-box: one 16-byte row per high nibble, low nibble picks the byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

    // Inverse S-box, same row/column layout as sbox.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
            default: row = '0;
        endcase
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

    // Round constant for key-schedule step r (1..10); zero elsewhere.
    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // One column of InvMixColumns: circulant {0e,0b,0d,09}.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  m [4];
        logic [31:0] res;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                res[31-8*r -: 8] = res[31-8*r -: 8] ^ gf_mul(a[j], m[(j - r + 4) % 4]);
        return res;
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Undo one key-schedule step: round key r -> round key r-1.
    function automatic logic [BLK_W-1:0] prev_key(input logic [BLK_W-1:0] k,
                                                   input logic [RND_W-1:0] r);
        logic [WORD_W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
        {a0, a1, a2, a3} = k;
        b3 = a3 ^ a2;
        b2 = a2 ^ a1;
        b1 = a1 ^ a0;
        b0 = a0 ^ sub_word(rot_word(b3)) ^ {rcon(r), 24'h0};
        return {b0, b1, b2, b3};
    endfunction

    // One forward key-schedule step: round key r-1 -> round key r.
    function automatic logic [BLK_W-1:0] next_key(input logic [BLK_W-1:0] k,
                                                   input logic [RND_W-1:0] r);
        logic [WORD_W-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
        {a0, a1, a2, a3} = k;
        b0 = a0 ^ sub_word(rot_word(a3)) ^ {rcon(r), 24'h0};
        b1 = a1 ^ b0;
        b2 = a2 ^ b1;
        b3 = a3 ^ b2;
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES-128 inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_dec_pkg::*;
(
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] pk,
    input  logic             last,
    output logic [BLK_W-1:0] nxt
);

    logic [BLK_W-1:0] t;
    logic [BLK_W-1:0] mixed;

    // Byte 4c+r is row r of column c; row r rotates right by r columns.
    always_comb begin
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*(4*((c - r + 4) % 4)+r) -: 8])
                                        ^ pk[127-8*(4*c+r) -: 8];
    end

    // Column mixing applied to every column of the keyed state.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++)
            mixed[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    end

    assign nxt = last ? t : mixed;

endmodule

// File: rtl/aes128_inv_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys derived
// backwards from k10 on the fly.
// Optional build macro: AES_DEC_FWD_KEY_EN -- key port carries k0 and a
// ten-cycle PREP phase expands it forward to k10 before the rounds start.
module aes128_inv_iter
    import aes_dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BLK_W-1:0] ct,
    input  logic [BLK_W-1:0] key,
    output logic             busy,
    output logic             done,
    output logic [BLK_W-1:0] pt
);

    state_t           state;
    logic [BLK_W-1:0] st;
    logic [BLK_W-1:0] rk;
    logic [RND_W-1:0] rnd;
    logic [BLK_W-1:0] pk;
    logic [BLK_W-1:0] round_out;
    logic             last;

    assign pk   = prev_key(rk, rnd);
    assign last = (rnd == 4'd1);

    aes_inv_round u_round (
        .st   (st),
        .pk   (pk),
        .last (last),
        .nxt  (round_out)
    );

`ifdef AES_DEC_FWD_KEY_EN
    logic [BLK_W-1:0] fk;
    assign fk = next_key(rk, rnd);
`endif

    // Control FSM with registered busy/done/pt; done is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            rnd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef AES_DEC_FWD_KEY_EN
                        st    <= ct;
                        rk    <= key;
                        rnd   <= 4'd1;
                        state <= PREP;
`else
                        st    <= ct ^ key;
                        rk    <= key;
                        rnd   <= RND_MAX;
                        state <= RUN;
`endif
                        busy  <= 1'b1;
                    end
                end
`ifdef AES_DEC_FWD_KEY_EN
                // Forward expansion k0 -> k10; the last step also whitens st.
                PREP: begin
                    rk <= fk;
                    if (rnd == RND_MAX) begin
                        st    <= st ^ fk;
                        state <= RUN;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
`endif
                RUN: begin
                    if (last) begin
                        pt    <= round_out;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        st  <= round_out;
                        rk  <= pk;
                        rnd <= rnd - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_inv_iter.sv
// Bench for aes128_inv_iter: FIPS-197 vectors plus random blocks produced by
// a forward AES-128 encryption model; a monitor pops expected plaintexts and
// done cycles whenever the DUT pulses done.
module tb_aes128_inv_iter;

`ifdef AES_DEC_FWD_KEY_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 10;
`endif

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n, start, busy, done;
    logic [127:0] ct, key, pt;

    aes128_inv_iter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ct(ct), .key(key),
        .busy(busy), .done(done), .pt(pt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] pt;
        int           cyc;
    } exp_t;
    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [127:0] last_pt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // ---------------- reference model: forward AES-128 ----------------
    logic [7:0] sb [256];

    // Carry-less product then polynomial reduction by 0x11b.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built from multiplicative inverse plus affine transform.
    task automatic init_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k0, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k0);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, res;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k0[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            k = round_key(k0, r);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    u[4*c+q] = sb[s[4*((c + q) % 4) + q]];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Key presented to the DUT for a given cipher key.
    function automatic logic [127:0] dut_key(input logic [127:0] k0);
`ifdef AES_DEC_FWD_KEY_EN
        return k0;
`else
        return round_key(k0, 10);
`endif
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 128'(cyc), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("pt", pt, mon_e.pt);
                chk("done_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic issue(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p,
                         input bit push, output int acc);
        @(negedge clk);
        wait_idle();
        start = 1'b1;
        ct    = c;
        key   = k;
        @(negedge clk);
        acc   = cyc;
        start = 1'b0;
        ct    = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_after_accept", 128'(busy), 128'(1));
        if (push) begin
            exp_q.push_back('{pt: p, cyc: acc + LAT});
            last_pt = p;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc, c0, bad;
        logic [127:0] p, k0, c;

        rst_n = 1'b0; start = 1'b0; ct = '0; key = '0; last_pt = '0;
        init_tables();
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_pt", pt, 128'(0));
        rst_n = 1'b1;

        // model sanity against published vectors
        chk("model_c1_ct", encrypt(C1_PT, C1_K0), C1_CT);
        chk("model_c1_k10", round_key(C1_K0, 10), C1_K10);
        chk("model_b_ct", encrypt(B_PT, B_K0), B_CT);

        // FIPS-197 C.1
`ifdef AES_DEC_FWD_KEY_EN
        issue(C1_CT, C1_K0, C1_PT, 1'b1, acc);
        while (cyc < acc + 10) @(negedge clk);
        chk("rk_after_prep", dut.rk, C1_K10);
`else
        issue(C1_CT, C1_K10, C1_PT, 1'b1, acc);
`endif
        drain();
        repeat (2) @(negedge clk);
        chk("pt_hold", pt, last_pt);

        // FIPS-197 App. B, single block
`ifdef AES_DEC_FWD_KEY_EN
        issue(B_CT, B_K0, B_PT, 1'b1, acc);
`else
        issue(B_CT, B_K10, B_PT, 1'b1, acc);
`endif
        drain();

        // start held high: three back-to-back blocks
        @(negedge clk);
        wait_idle();
        c0    = cyc;
        start = 1'b1;
        ct    = B_CT;
        key   = dut_key(B_K0);
        for (int j = 0; j < 3; j++)
            exp_q.push_back('{pt: B_PT, cyc: c0 + 1 + j * (LAT + 1) + LAT});
        last_pt = B_PT;
        while (cyc < c0 + 1 + 2 * (LAT + 1)) @(negedge clk);
        start = 1'b0;
        drain();

        // start pulses while busy are dropped
        issue(C1_CT, dut_key(C1_K0), C1_PT, 1'b1, acc);
        bad = 0;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            if (!busy) bad++;
            start = (k == 2 || k == 6);
            ct    = B_CT;
            key   = dut_key(B_K0);
        end
        start = 1'b0;
        chk("busy_hold", 128'(bad), 128'(0));
        drain();
        repeat (LAT + 3) @(negedge clk);
        chk("no_extra_block", 128'(busy), 128'(0));

        // reset mid-operation
        issue(B_CT, dut_key(B_K0), B_PT, 1'b0, acc);
        while (cyc < acc + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_pt", pt, 128'(0));
        repeat (LAT + 4) @(negedge clk);
        chk("midrst_idle", 128'(busy), 128'(0));
        issue(C1_CT, dut_key(C1_K0), C1_PT, 1'b1, acc);
        drain();

        // reset coinciding with start
        @(negedge clk);
        start = 1'b1; rst_n = 1'b0; ct = B_CT; key = dut_key(B_K0);
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        chk("rst_start_busy", 128'(busy), 128'(0));
        repeat (LAT + 4) @(negedge clk);
        chk("rst_start_pt", pt, 128'(0));

        // random blocks
        for (int n = 0; n < 8; n++) begin
            p  = {$urandom, $urandom, $urandom, $urandom};
            k0 = {$urandom, $urandom, $urandom, $urandom};
            c  = encrypt(p, k0);
            issue(c, dut_key(k0), p, 1'b1, acc);
        end
        drain();
        repeat (2) @(negedge clk);
        chk("final_pt_hold", pt, last_pt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_inv_iter.md
# aes128_inv_iter

Iterative AES-128 inverse cipher: decrypts one 128-bit block over ten clock cycles, one inverse round per cycle, deriving round keys backwards on the fly from the last round key. It is the decrypt-side counterpart of the pipelined encryption rounds in the tiny_aes core. It sits behind the same 128-bit state/key datapath and serves area-constrained decrypt paths where a fully unrolled inverse pipeline is too large.

## Interface
- No parameters; block size 128 and round count 10 are fixed constants in the package.
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- ct  in  128  ciphertext, byte 0 at [127:120]; sampled with start.
- key  in  128  decryption key: round-10 key k10 by default; cipher key k0 with AES_DEC_FWD_KEY_EN. Sampled with start.
- busy  out  1  high while a block is in flight; start is ignored while high.
- done  out  1  one-cycle pulse; pt valid from this cycle.
- pt  out  128  plaintext; held until the next done or reset.

## Operation
- FSM states: IDLE, RUN, plus PREP with AES_DEC_FWD_KEY_EN.
- IDLE, start=1: st <= ct ^ key, rk <= key, rnd <= 10, go to RUN, busy <= 1.
- RUN, each cycle:
  - pk = prev_key(rk, rnd): b3=a3^a2, b2=a2^a1, b1=a1^a0, b0=a0^SubWord(RotWord(b3))^Rcon[rnd].
  - Rcon[10..1] = 36,1b,80,40,20,10,08,04,02,01.
  - t = InvSubBytes(InvShiftRows(st)) ^ pk.
  - rnd>1: st <= InvMixColumns(t), rk <= pk, rnd <= rnd-1.
  - rnd==1: pt <= t, done <= 1, busy <= 0, go to IDLE.
- done deasserts the following cycle unconditionally.
- start with busy=1 is dropped; it is neither queued nor flagged.
- All XORs are bytewise over GF(2); InvMixColumns uses the {0e,0b,0d,09} matrix with xtime reduction by 0x11b.

## Timing
- Reset: busy=0, done=0, pt=0, FSM=IDLE, st/rk/rnd=0.
- Edge E0 accepts start. Rounds execute at E1..E10. done and pt are visible after E10, i.e. latency 10 cycles from acceptance.
- Next start is accepted at E11 at the earliest, giving 11 cycles per block. start held high gives back-to-back blocks every 11 cycles.
- ct/key are don't-care after E0.
- rst_n low mid-operation (any round): the next edge returns to IDLE with all outputs at reset values. No done is produced and pt is cleared.
- rst_n low coinciding with start: reset wins.

## Configuration
- AES_DEC_FWD_KEY_EN defined:
  - key is the cipher key k0.
  - IDLE+start goes to PREP (rk <= key, rnd <= 1); st <= ct is latched.
  - PREP runs forward expansion for 10 cycles, rnd 1..10, ending with rk = k10.
  - It then goes to RUN with st <= st ^ k10 and rnd <= 10.
  - Latency 20 cycles; throughput 21 cycles/block.
- AES_DEC_FWD_KEY_EN undefined: key is k10; PREP is absent; latency as in Timing.

## Structure
- Package aes_dec_pkg holds:
  - sbox and inv_sbox functions (256-entry constant case)
  - rcon function
  - xtime and gf_mul helpers
  - FSM state typedef
  - NR=10 and block-width constants
- Sub-module aes_inv_round (combinational): inputs st, pk, last flag; output next state. It keeps the round datapath separable from the FSM and key schedule.

## Test plan
- FIPS-197 App. C.1: ct 69c4e0d86a7b0430d8cdb78070b4c55a, key 13111d7fe3944a17f307a78b4d2b30c5, start 1 cycle -> done at +10, pt 00112233445566778899aabbccddeeff.
- FIPS-197 App. B: ct 3925841d02dc09fbdc118597196a0b32, key d014f9a8c9ee2589e13f0cc8b6630ca6 -> pt 3243f6a8885a308d313198a2e0370734. Then hold start high for three blocks -> done every 11 cycles, pt correct each time.
- start pulsed at +3 and +7 during a block -> ignored; single done at +10 with the original pt; busy stays high throughout.
- rst_n low at cycle +5 for one cycle -> busy=0, done never pulses, pt=0. A new C.1 request afterwards completes correctly.
- AES_DEC_FWD_KEY_EN build: key 000102030405060708090a0b0c0d0e0f with the C.1 ct -> done at +20, pt 00112233445566778899aabbccddeeff. Internal rk equals 13111d7fe3944a17f307a78b4d2b30c5 on leaving PREP.
